// File: rtl/rgb2ycbcr_conv.sv
// RGB to YCbCr converter: 3-stage fixed-point pipeline with valid/ready backpressure.
// Supports BT.601 and BT.709 coefficient sets; a set change takes effect only at frame boundaries.
module rgb2ycbcr_conv #(
  parameter int DW   = 8,
  parameter int FRAC = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] r_in,
  input  logic [DW-1:0] g_in,
  input  logic [DW-1:0] b_in,
  input  logic          valid_in,
  input  logic          frame_end_in,
  input  logic          mode_in,
  output logic          in_ready,
  output logic          valid_out,
  output logic          frame_end_out,
  output logic          mode_out,
  output logic [DW-1:0] y_out,
  output logic [DW-1:0] cb_out,
  output logic [DW-1:0] cr_out,
  input  logic          out_ready
);
  localparam int KW = FRAC + 2;
  localparam int PW = DW + FRAC + 3;
  localparam int SW = PW + 2;
  localparam int OW = DW + 3;

  typedef logic signed [KW-1:0] coef_t;
  typedef logic signed [PW-1:0] prod_t;
  typedef logic signed [OW-1:0] acc_t;

  // Rounds half away from zero so that negative coefficients mirror positive ones.
  function automatic coef_t kq(input real c);
    real s;
    s = c * (2.0 ** FRAC);
    if (s >= 0.0) return KW'($rtoi(s + 0.5));
    return KW'(-$rtoi(0.5 - s));
  endfunction

  // Row order: Y(R,G,B), Cb(R,G,B), Cr(R,G,B)
  localparam coef_t K601 [9] = '{kq(0.299), kq(0.587), kq(0.114),
                                 kq(-0.168736), kq(-0.331264), kq(0.5),
                                 kq(0.5), kq(-0.418688), kq(-0.081312)};
  localparam coef_t K709 [9] = '{kq(0.2126), kq(0.7152), kq(0.0722),
                                 kq(-0.114572), kq(-0.385428), kq(0.5),
                                 kq(0.5), kq(-0.454153), kq(-0.045847)};

  localparam logic signed [SW-1:0] RND = SW'(1) << (FRAC - 1);
  localparam logic signed [SW-1:0] OFS = SW'(1) << (DW - 1 + FRAC);

  logic                 en, accept, eff_mode;
  logic                 active_mode, frame_idle;
  logic [DW-1:0]        pix [3];
  coef_t                coef [9];
  prod_t                s1_prod [9];
  logic                 s1_v, s1_fe, s1_mode;
  logic signed [SW-1:0] sum [3];
  acc_t                 s2_acc [3];
  logic                 s2_v, s2_fe, s2_mode;
  logic [DW-1:0]        sat [3];

  assign en       = ~valid_out | out_ready;
  assign in_ready = en;
  assign accept   = valid_in & en;
  assign eff_mode = frame_idle ? mode_in : active_mode;
  assign pix[0]   = r_in;
  assign pix[1]   = g_in;
  assign pix[2]   = b_in;

  always_comb begin
    for (int unsigned i = 0; i < 9; i++) coef[i] = eff_mode ? K709[i] : K601[i];
  end

  // Mode is sampled on the first accepted pixel of a frame and held until its frame_end pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_mode <= 1'b0;
      frame_idle  <= 1'b1;
    end else if (accept) begin
      active_mode <= eff_mode;
      frame_idle  <= frame_end_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v    <= 1'b0;
      s1_fe   <= 1'b0;
      s1_mode <= 1'b0;
      for (int unsigned i = 0; i < 9; i++) s1_prod[i] <= '0;
    end else if (en) begin
      s1_v  <= valid_in;
      s1_fe <= valid_in & frame_end_in;
      if (valid_in) begin
        s1_mode <= eff_mode;
        for (int unsigned i = 0; i < 9; i++)
          s1_prod[i] <= PW'($signed({1'b0, pix[i % 3]})) * PW'(coef[i]);
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < 3; c++) begin
      sum[c] = SW'(s1_prod[3*c]) + SW'(s1_prod[3*c+1]) + SW'(s1_prod[3*c+2]) + RND;
      if (c != 0) sum[c] = sum[c] + OFS;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_v    <= 1'b0;
      s2_fe   <= 1'b0;
      s2_mode <= 1'b0;
      for (int unsigned c = 0; c < 3; c++) s2_acc[c] <= '0;
    end else if (en) begin
      s2_v  <= s1_v;
      s2_fe <= s1_fe;
      if (s1_v) begin
        s2_mode <= s1_mode;
        for (int unsigned c = 0; c < 3; c++) s2_acc[c] <= OW'(sum[c] >>> FRAC);
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < 3; c++) begin
      sat[c] = s2_acc[c][DW-1:0];
      if (s2_acc[c][OW-1])             sat[c] = '0;
      else if (|s2_acc[c][OW-2:DW])    sat[c] = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out     <= 1'b0;
      frame_end_out <= 1'b0;
      mode_out      <= 1'b0;
      y_out         <= '0;
      cb_out        <= '0;
      cr_out        <= '0;
    end else if (en) begin
      valid_out     <= s2_v;
      frame_end_out <= s2_fe;
      if (s2_v) begin
        mode_out <= s2_mode;
        y_out    <= sat[0];
        cb_out   <= sat[1];
        cr_out   <= sat[2];
      end
    end
  end
endmodule

// File: tb/tb_rgb2ycbcr_conv.sv
// Scoreboard bench for rgb2ycbcr_conv: DW=8/FRAC=16 directed and stall tests, DW=10/FRAC=18 random sweep.
module tb_rgb2ycbcr_conv;
  typedef struct {int y; int cb; int cr; bit m; bit fe;} exp_t;

  int vectors = 0, miscompares = 0;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] r8 = '0, g8 = '0, b8 = '0, y8, cb8, cr8;
  logic v8 = 1'b0, fe8 = 1'b0, m8 = 1'b0, or8 = 1'b1, ir8, vo8, feo8, mo8;
  logic [9:0] r10 = '0, g10 = '0, b10 = '0, y10, cb10, cr10;
  logic v10 = 1'b0, fe10 = 1'b0, m10 = 1'b0, or10 = 1'b1, ir10, vo10, feo10, mo10;

  exp_t q8[$], q10[$];
  bit idle8 = 1, amode8 = 0, idle10 = 1, amode10 = 0;

  rgb2ycbcr_conv #(.DW(8), .FRAC(16)) u_dut8 (
    .clk(clk), .reset(reset), .r_in(r8), .g_in(g8), .b_in(b8), .valid_in(v8),
    .frame_end_in(fe8), .mode_in(m8), .in_ready(ir8), .valid_out(vo8),
    .frame_end_out(feo8), .mode_out(mo8), .y_out(y8), .cb_out(cb8), .cr_out(cr8),
    .out_ready(or8));

  rgb2ycbcr_conv #(.DW(10), .FRAC(18)) u_dut10 (
    .clk(clk), .reset(reset), .r_in(r10), .g_in(g10), .b_in(b10), .valid_in(v10),
    .frame_end_in(fe10), .mode_in(m10), .in_ready(ir10), .valid_out(vo10),
    .frame_end_out(feo10), .mode_out(mo10), .y_out(y10), .cb_out(cb10), .cr_out(cr10),
    .out_ready(or10));

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic real coef(input bit m, input int i);
    real c[9];
    if (m) c = '{0.2126, 0.7152, 0.0722, -0.114572, -0.385428, 0.5, 0.5, -0.454153, -0.045847};
    else   c = '{0.299, 0.587, 0.114, -0.168736, -0.331264, 0.5, 0.5, -0.418688, -0.081312};
    return c[i];
  endfunction

  function automatic longint kq(input real c, input int frac);
    real s;
    s = c * (2.0 ** frac);
    if (s >= 0.0) return longint'($rtoi(s + 0.5));
    return -longint'($rtoi(0.5 - s));
  endfunction

  // Y/Cb/Cr = round(sum(component * K) / 2^frac) (+ half-scale offset for chroma), clamped to dw bits
  function automatic exp_t model(input int dw, input int frac, input bit m,
                                 input int r, input int g, input int b, input bit fe);
    exp_t e;
    int px[3];
    int res[3];
    longint acc, v, vmax;
    px = '{r, g, b};
    vmax = (longint'(1) << dw) - 1;
    for (int c = 0; c < 3; c++) begin
      acc = longint'(1) << (frac - 1);
      if (c > 0) acc += longint'(1) << (dw - 1 + frac);
      for (int k = 0; k < 3; k++) acc += longint'(px[k]) * kq(coef(m, 3*c + k), frac);
      v = acc >>> frac;
      if (v < 0) v = 0;
      else if (v > vmax) v = vmax;
      res[c] = int'(v);
    end
    e.y = res[0]; e.cb = res[1]; e.cr = res[2]; e.m = m; e.fe = fe;
    return e;
  endfunction

  function automatic exp_t mk(input int y, input int cb, input int cr, input bit m, input bit fe);
    exp_t e;
    e.y = y; e.cb = cb; e.cr = cr; e.m = m; e.fe = fe;
    return e;
  endfunction

  // Monitor for the 8-bit instance: handshakes, stall hold and in_ready rule.
  bit held = 0;
  logic [7:0] hy, hcb, hcr;
  logic hm, hfe;
  always @(negedge clk) begin
    exp_t e;
    if (reset) held = 0;
    else begin
      chk("in_ready8", int'(ir8), int'(!vo8 || or8));
      if (held) begin
        chk("hold_valid", int'(vo8), 1);
        chk("hold_y", int'(y8), int'(hy));
        chk("hold_cb", int'(cb8), int'(hcb));
        chk("hold_cr", int'(cr8), int'(hcr));
        chk("hold_mode", int'(mo8), int'(hm));
        chk("hold_fe", int'(feo8), int'(hfe));
      end
      held = vo8 && !or8;
      hy = y8; hcb = cb8; hcr = cr8; hm = mo8; hfe = feo8;
      if (vo8 && or8) begin
        if (q8.size() == 0) chk("spurious_valid8", int'(vo8), 0);
        else begin
          e = q8.pop_front();
          chk("y8", int'(y8), e.y);
          chk("cb8", int'(cb8), e.cb);
          chk("cr8", int'(cr8), e.cr);
          chk("mode8", int'(mo8), int'(e.m));
          chk("fe8", int'(feo8), int'(e.fe));
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && vo10 && or10) begin
      if (q10.size() == 0) chk("spurious_valid10", int'(vo10), 0);
      else begin
        e = q10.pop_front();
        chk("y10", int'(y10), e.y);
        chk("cb10", int'(cb10), e.cb);
        chk("cr10", int'(cr10), e.cr);
        chk("mode10", int'(mo10), int'(e.m));
        chk("fe10", int'(feo10), int'(e.fe));
      end
    end
  end

  task automatic send8(input int r, input int g, input int b, input bit fe, input bit m,
                       input bit use_e, input exp_t e_in);
    bit acc;
    bit em;
    acc = 0;
    r8 = 8'(r); g8 = 8'(g); b8 = 8'(b); fe8 = fe; m8 = m; v8 = 1'b1;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      if (ir8) begin
        acc = 1;
        em = idle8 ? m : amode8;
        amode8 = em;
        idle8 = fe;
        q8.push_back(use_e ? e_in : model(8, 16, em, r, g, b, fe));
      end
      @(posedge clk); #1;
    end
    chk("accept8", int'(acc), 1);
    v8 = 1'b0; fe8 = 1'b0;
  endtask

  task automatic send10(input int r, input int g, input int b, input bit fe, input bit m,
                        input bit grey);
    bit acc;
    bit em;
    exp_t e;
    acc = 0;
    r10 = 10'(r); g10 = 10'(g); b10 = 10'(b); fe10 = fe; m10 = m; v10 = 1'b1;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      if (ir10) begin
        acc = 1;
        em = idle10 ? m : amode10;
        amode10 = em;
        idle10 = fe;
        e = model(10, 18, em, r, g, b, fe);
        if (grey) begin e.cb = 512; e.cr = 512; end
        q10.push_back(e);
      end
      @(posedge clk); #1;
    end
    chk("accept10", int'(acc), 1);
    v10 = 1'b0; fe10 = 1'b0;
  endtask

  task automatic idle(input int n);
    v8 = 1'b0;
    repeat (n) begin
      m8 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; v8 = 1'b0; v10 = 1'b0;
    q8.delete(); q10.delete();
    idle8 = 1; amode8 = 0; idle10 = 1; amode10 = 0;
    @(posedge clk); #1;
    chk("rst_valid_out", int'(vo8), 0);
    chk("rst_in_ready", int'(ir8), 1);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  exp_t dummy;
  initial begin
    dummy = mk(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vo", int'(vo8), 0);
    chk("rst_y", int'(y8), 0);
    chk("rst_cb", int'(cb8), 0);
    chk("rst_cr", int'(cr8), 0);
    chk("rst_mode", int'(mo8), 0);
    chk("rst_fe", int'(feo8), 0);
    chk("rst_ir", int'(ir8), 1);
    reset = 1'b0;

    // BT.601 known values, back-to-back
    send8(255, 255, 255, 0, 0, 1, mk(255, 128, 128, 0, 0));
    send8(0, 0, 0, 0, 0, 1, mk(0, 128, 128, 0, 0));
    send8(255, 0, 0, 0, 0, 1, mk(76, 85, 255, 0, 0));
    send8(0, 255, 0, 0, 0, 1, mk(150, 44, 21, 0, 0));
    idle(6);

    // BT.709 red as first pixel after reset
    do_reset();
    send8(255, 0, 0, 0, 1, 1, mk(54, 99, 255, 1, 0));
    idle(5);

    // Mode switch inside a frame is ignored until the next frame
    send8(10, 20, 30, 1, 1, 0, dummy);
    send8(200, 40, 90, 0, 0, 1, model(8, 16, 0, 200, 40, 90, 0));
    send8(13, 250, 7, 0, 1, 1, model(8, 16, 0, 13, 250, 7, 0));
    send8(99, 99, 1, 0, 1, 1, model(8, 16, 0, 99, 99, 1, 0));
    send8(0, 5, 255, 1, 1, 1, model(8, 16, 0, 0, 5, 255, 1));
    send8(255, 0, 0, 1, 1, 1, mk(54, 99, 255, 1, 1));
    idle(5);

    // Backpressure: random gaps, 5-cycle downstream stall, frame_end on the 10th
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), i == 9, 1'($urandom_range(0, 1)), 0, dummy);
          idle(int'($urandom_range(0, 2)));
        end
      end
      begin
        repeat (7) @(posedge clk);
        #1 or8 = 1'b0;
        repeat (5) @(posedge clk);
        #1 or8 = 1'b1;
      end
    join
    idle(6);

    // Reset with stalled output and pixels in flight
    or8 = 1'b0;
    send8(255, 255, 255, 0, 0, 0, dummy);
    send8(40, 80, 120, 0, 0, 0, dummy);
    send8(7, 7, 7, 0, 0, 0, dummy);
    idle(3);
    do_reset();
    or8 = 1'b1;
    send8(255, 0, 0, 0, 1, 1, mk(54, 99, 255, 1, 0));
    idle(6);

    // DW=10 / FRAC=18 random sweep, including grey
    send10(0, 0, 0, 1, 0, 0);
    send10(512, 512, 512, 1, 0, 1);
    send10(512, 512, 512, 1, 1, 1);
    for (int i = 0; i < 200; i++) begin
      send10(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
             int'($urandom_range(0, 1023)), $urandom_range(0, 3) == 0,
             1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    for (int t = 0; t < 50 && (q8.size() != 0 || q10.size() != 0); t++) @(posedge clk);
    #1;
    chk("drain8", q8.size(), 0);
    chk("drain10", q10.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
